// File: rtl/spi_shift_reg_if.sv
// Bus bundle for spi_shift_reg: the controller drives the strobes and data,
// the shift register drives the word, serial bit and status back.
interface spi_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             shift;
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             serial_out;
    logic             busy;
    logic             done;
    logic             parity_out;

    modport master (
        output ena, load, data_in, shift, serial_in,
        input  data_out, serial_out, busy, done, parity_out
    );

    modport slave (
        input  ena, load, data_in, shift, serial_in,
        output data_out, serial_out, busy, done, parity_out
    );
endinterface

// File: rtl/spi_shift_reg.sv
// Parallel-load / serial-shift register with remaining-bit counter, shared SPI data path.
// Define SPI_SHIFT_REG_PARITY_EN to build the even-parity output of each completed word.
module spi_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            rst,
    spi_shift_reg_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             done_q;
    logic [WIDTH-1:0] shifted;
    logic             accept_load;
    logic             accept_shift;
    logic             last_shift;

    // Load always beats a simultaneous shift, including the final one.
    assign accept_load  = bus.ena & bus.load;
    assign accept_shift = bus.ena & bus.shift & (state == SHIFT) & ~bus.load;
    assign last_shift   = (cnt == CW'(1));

    always_comb begin
        shifted = sreg;
        if (MSB_FIRST != 0)
            shifted = {sreg[WIDTH-2:0], bus.serial_in};
        else
            shifted = {bus.serial_in, sreg[WIDTH-1:1]};
    end

`ifdef SPI_SHIFT_REG_PARITY_EN
    logic parity_q;
`endif

    // done drops back every cycle regardless of ena, so it is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
`ifdef SPI_SHIFT_REG_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept_load) begin
                sreg  <= bus.data_in;
                cnt   <= CW'(WIDTH);
                state <= SHIFT;
            end else if (accept_shift) begin
                sreg <= shifted;
                cnt  <= cnt - CW'(1);
                if (last_shift) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
`ifdef SPI_SHIFT_REG_PARITY_EN
                    parity_q <= ^shifted;
`endif
                end
            end
        end
    end

    assign bus.data_out   = sreg;
    assign bus.serial_out = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
    assign bus.busy       = (state == SHIFT);
    assign bus.done       = done_q;
`ifdef SPI_SHIFT_REG_PARITY_EN
    assign bus.parity_out = parity_q;
`else
    assign bus.parity_out = 1'b0;
`endif
endmodule

// File: tb/tb_spi_shift_reg.sv
// Self-checking bench: an MSB-first and an LSB-first instance checked every cycle
// against a word/bit-count model, plus literal checks from hand-worked examples.
module tb_spi_shift_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    spi_shift_reg_if #(.WIDTH(8)) ifa ();
    spi_shift_reg_if #(.WIDTH(8)) ifb ();

    spi_shift_reg #(.WIDTH(8), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    spi_shift_reg #(.WIDTH(8), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Model: loaded word, number of accepted shifts, received bits, status.
    logic [63:0] m_w [2];
    logic [63:0] m_rx [2];
    int          m_k [2];
    bit          m_act [2];
    bit          m_done [2];
    bit          m_par [2];

    function automatic logic [7:0] model_data(int i);
        logic [63:0] d;
        if (i == 0)
            d = (m_w[i] << m_k[i]) | m_rx[i];
        else
            d = (m_w[i] >> m_k[i]) | (m_rx[i] << (8 - m_k[i]));
        return d[7:0];
    endfunction

    function automatic logic model_serial(int i);
        logic [7:0] d;
        d = model_data(i);
        return (i == 0) ? d[7] : d[0];
    endfunction

    task automatic model_step(int i, logic e, logic l, logic [7:0] din, logic s, logic si);
        m_done[i] = 1'b0;
        if (e && l) begin
            m_w[i]   = 64'(din);
            m_k[i]   = 0;
            m_rx[i]  = '0;
            m_act[i] = 1'b1;
        end else if (e && s && m_act[i]) begin
            if (i == 0)
                m_rx[i] = (m_rx[i] << 1) | 64'(si);
            else
                m_rx[i] = m_rx[i] | (64'(si) << m_k[i]);
            m_k[i] = m_k[i] + 1;
            if (m_k[i] == 8) begin
                m_act[i]  = 1'b0;
                m_done[i] = 1'b1;
`ifdef SPI_SHIFT_REG_PARITY_EN
                m_par[i] = ^model_data(i);
`endif
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_w[i] = '0; m_rx[i] = '0; m_k[i] = 0;
                m_act[i] = 1'b0; m_done[i] = 1'b0; m_par[i] = 1'b0;
            end
        end else begin
            model_step(0, ifa.ena, ifa.load, ifa.data_in, ifa.shift, ifa.serial_in);
            model_step(1, ifb.ena, ifb.load, ifb.data_in, ifb.shift, ifb.serial_in);
        end
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        checkOutput("a.data_out",   32'(ifa.data_out),   32'(model_data(0)));
        checkOutput("a.serial_out", 32'(ifa.serial_out), 32'(model_serial(0)));
        checkOutput("a.busy",       32'(ifa.busy),       32'(m_act[0]));
        checkOutput("a.done",       32'(ifa.done),       32'(m_done[0]));
        checkOutput("a.parity_out", 32'(ifa.parity_out), 32'(m_par[0]));
        checkOutput("b.data_out",   32'(ifb.data_out),   32'(model_data(1)));
        checkOutput("b.serial_out", 32'(ifb.serial_out), 32'(model_serial(1)));
        checkOutput("b.busy",       32'(ifb.busy),       32'(m_act[1]));
        checkOutput("b.done",       32'(ifb.done),       32'(m_done[1]));
        checkOutput("b.parity_out", 32'(ifb.parity_out), 32'(m_par[1]));
    end

    task automatic applyStimulus(int sel, logic e, logic l, logic [7:0] d, logic s, logic si);
        if (sel == 0) begin
            ifa.ena = e; ifa.load = l; ifa.data_in = d; ifa.shift = s; ifa.serial_in = si;
            ifb.ena = 1'b0; ifb.load = 1'b0; ifb.shift = 1'b0;
        end else begin
            ifb.ena = e; ifb.load = l; ifb.data_in = d; ifb.shift = s; ifb.serial_in = si;
            ifa.ena = 1'b0; ifa.load = 1'b0; ifa.shift = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic doLoad(int sel, logic [7:0] d);
        applyStimulus(sel, 1'b1, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic doShift(int sel, logic si);
        applyStimulus(sel, 1'b1, 1'b0, 8'h00, 1'b1, si);
    endtask

    logic [7:0] rx_bits;
    logic [7:0] tx_seq;
    logic       par_exp;

    initial begin
        ifa.ena = 0; ifa.load = 0; ifa.data_in = 0; ifa.shift = 0; ifa.serial_in = 0;
        ifb.ena = 0; ifb.load = 0; ifb.data_in = 0; ifb.shift = 0; ifb.serial_in = 0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset data_out", 32'(ifa.data_out), 32'h0);
        checkOutput("reset serial_out", 32'(ifa.serial_out), 32'h0);
        checkOutput("reset busy", 32'(ifa.busy), 32'h0);
        checkOutput("reset done", 32'(ifa.done), 32'h0);
        checkOutput("reset parity", 32'(ifa.parity_out), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic MSB-first word.
        doLoad(0, 8'hA5);
        rx_bits = 8'b0011_1101;
        tx_seq  = 8'b1010_0101;
        for (int j = 0; j < 8; j++) begin
            checkOutput("basic serial_out", 32'(ifa.serial_out), 32'(tx_seq[7-j]));
            checkOutput("basic busy", 32'(ifa.busy), 32'h1);
            doShift(0, rx_bits[7-j]);
        end
        checkOutput("basic data_out", 32'(ifa.data_out), 32'h3D);
        checkOutput("basic model data", 32'(model_data(0)), 32'h3D);
        checkOutput("basic done", 32'(ifa.done), 32'h1);
        checkOutput("basic busy end", 32'(ifa.busy), 32'h0);
`ifdef SPI_SHIFT_REG_PARITY_EN
        par_exp = 1'b1;
`else
        par_exp = 1'b0;
`endif
        checkOutput("basic parity", 32'(ifa.parity_out), 32'(par_exp));
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("basic done pulse", 32'(ifa.done), 32'h0);

        // LSB-first word.
        doLoad(1, 8'h01);
        tx_seq = 8'b1000_0000;
        for (int j = 0; j < 8; j++) begin
            checkOutput("lsb serial_out", 32'(ifb.serial_out), 32'(tx_seq[7-j]));
            doShift(1, 1'b1);
        end
        checkOutput("lsb data_out", 32'(ifb.data_out), 32'hFF);
        checkOutput("lsb done", 32'(ifb.done), 32'h1);
        checkOutput("lsb parity", 32'(ifb.parity_out), 32'h0);

        // Gaps with ena low and shift still strobed, then an idle shift.
        doLoad(0, 8'hF0);
        rx_bits = 8'b0000_1010;
        for (int j = 0; j < 4; j++) begin
            doShift(0, rx_bits[3-j]);
            applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            checkOutput("gap busy", 32'(ifa.busy), 32'h1);
        end
        checkOutput("gap data_out", 32'(ifa.data_out), 32'h0A);
        for (int j = 0; j < 4; j++) doShift(0, 1'b1);
        checkOutput("gap done", 32'(ifa.done), 32'h1);
        checkOutput("gap final data", 32'(ifa.data_out), 32'hAF);
        doShift(0, 1'b0);
        checkOutput("idle shift data", 32'(ifa.data_out), 32'hAF);
        checkOutput("idle shift done", 32'(ifa.done), 32'h0);

        // Load collides with the 8th shift.
        doLoad(0, 8'h12);
        for (int j = 0; j < 7; j++) doShift(0, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
        checkOutput("collide done", 32'(ifa.done), 32'h0);
        checkOutput("collide data", 32'(ifa.data_out), 32'h55);
        checkOutput("collide busy", 32'(ifa.busy), 32'h1);
        for (int j = 0; j < 8; j++) doShift(0, 1'b1);
        checkOutput("collide redo done", 32'(ifa.done), 32'h1);
        checkOutput("collide redo data", 32'(ifa.data_out), 32'hFF);

        // Back-to-back load in the done cycle.
        doLoad(0, 8'h3C);
        checkOutput("b2b done", 32'(ifa.done), 32'h0);
        checkOutput("b2b busy", 32'(ifa.busy), 32'h1);
        checkOutput("b2b data", 32'(ifa.data_out), 32'h3C);

        // Reset abort after 3 shifts.
        for (int j = 0; j < 3; j++) doShift(0, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort data", 32'(ifa.data_out), 32'h0);
        checkOutput("abort busy", 32'(ifa.busy), 32'h0);
        checkOutput("abort done", 32'(ifa.done), 32'h0);
        checkOutput("abort serial", 32'(ifa.serial_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        doLoad(0, 8'h81);
        checkOutput("post reset data", 32'(ifa.data_out), 32'h81);
        for (int j = 0; j < 8; j++) doShift(0, j[0]);
        checkOutput("post reset done", 32'(ifa.done), 32'h1);
        checkOutput("post reset word", 32'(ifa.data_out), 32'h55);
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
